// File: rtl/wb_dec_pkg.sv
// Shared types and constants for the Wishbone peripheral address decoder.
package wb_dec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UNMAPPED = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } err_code_e;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_dec_watchdog.sv
// Access watchdog: counter cleared by load_i, counts while en_i, flags timeout unless acked.
// Only built when WB_DEC_TIMEOUT_EN is defined.
`ifdef WB_DEC_TIMEOUT_EN
module wb_dec_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  input  logic ack_i,
  output logic timeout_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntLast)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack in the final cycle wins over the timeout.
  assign timeout_o = en_i && !ack_i && (cnt_q == CntLast);

endmodule
`endif

// File: rtl/wb_perips_decoder.sv
// Single-master Wishbone classic decoder routing requests to 4 KiB slave windows.
// Define WB_DEC_TIMEOUT_EN to build the access watchdog (err_code 2).
module wb_perips_decoder
  import wb_dec_pkg::*;
#(
  parameter int unsigned          NUM_SLAVES     = 13,
  parameter int unsigned          AD_WIDTH       = 32,
  parameter int unsigned          DAT_WIDTH      = 32,
  parameter logic [AD_WIDTH-1:0]  BASE_ADDR      = AD_WIDTH'(32'h1000_0000),
  parameter int unsigned          SLV_ADDR_LSB   = 12,
  parameter int unsigned          TIMEOUT_CYCLES = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            wbs_cyc_i,
  input  logic                            wbs_stb_i,
  input  logic                            wbs_we_i,
  input  logic [AD_WIDTH-1:0]             wbs_addr_i,
  input  logic [DAT_WIDTH-1:0]            wbs_wdata_i,
  input  logic [DAT_WIDTH/8-1:0]          wbs_sel_i,
  output logic [DAT_WIDTH-1:0]            wbs_rdata_o,
  output logic                            wbs_ack_o,
  output logic                            wbs_err_o,
  output logic [NUM_SLAVES-1:0]           wbm_slave_cyc_o,
  output logic [NUM_SLAVES-1:0]           wbm_slave_stb_o,
  output logic                            wbm_slave_we_o,
  output logic [AD_WIDTH-1:0]             wbm_slave_addr_o,
  output logic [DAT_WIDTH-1:0]            wbm_slave_wdata_o,
  output logic [DAT_WIDTH/8-1:0]          wbm_slave_sel_o,
  input  logic [NUM_SLAVES*DAT_WIDTH-1:0] slave_wbm_rdata_i,
  input  logic [NUM_SLAVES-1:0]           slave_wbm_ack_i,
  input  logic                            err_clr_i,
  output logic                            err_irq_o,
  output logic [AD_WIDTH-1:0]             err_addr_o,
  output logic [1:0]                      err_code_o
);

  localparam int unsigned SelW = DAT_WIDTH / 8;
  localparam int unsigned IdxW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [DAT_WIDTH-1:0] ErrData = DAT_WIDTH'(ERR_DATA);

  state_e                state_d, state_q;
  err_code_e             err_code_d, err_code_q;
  logic [AD_WIDTH-1:0]   err_addr_d, err_addr_q;
  logic [AD_WIDTH-1:0]   addr_q;
  logic [DAT_WIDTH-1:0]  wdata_q, rdata_q, sel_rdata;
  logic [SelW-1:0]       sel_q;
  logic [IdxW-1:0]       idx_q;
  logic                  we_q, resp_err_q, sel_ack, timeout;
  logic                  req, mapped, unmapped_ev, err_ev;
  logic [AD_WIDTH-1:0]   offset, idx_full;

  assign req      = wbs_cyc_i & wbs_stb_i;
  assign offset   = wbs_addr_i - BASE_ADDR;
  assign idx_full = offset >> SLV_ADDR_LSB;
  assign mapped   = (wbs_addr_i >= BASE_ADDR) && (idx_full < AD_WIDTH'(NUM_SLAVES));

  // Only the selected slave's ack and data are observed.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_ack   = slave_wbm_ack_i[i];
        sel_rdata = slave_wbm_rdata_i[i*DAT_WIDTH +: DAT_WIDTH];
      end
    end
  end

`ifdef WB_DEC_TIMEOUT_EN
  logic wd_timeout;

  wb_dec_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    ((state_q == IDLE) && req && mapped),
    .en_i      (state_q == ACCESS),
    .ack_i     (sel_ack),
    .timeout_o (wd_timeout)
  );

  // An abort takes precedence, so a dropped cycle never records a timeout.
  assign timeout = wd_timeout & wbs_cyc_i;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = mapped ? ACCESS : RESP;
      end
      ACCESS: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (sel_ack || timeout) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wbs_ack_o         = (state_q == RESP);
    wbs_err_o         = (state_q == RESP) && resp_err_q;
    wbs_rdata_o       = (state_q == RESP) ? rdata_q : '0;
    wbm_slave_cyc_o   = (state_q == ACCESS) ? (NUM_SLAVES'(1) << idx_q) : '0;
    wbm_slave_stb_o   = wbm_slave_cyc_o;
    wbm_slave_we_o    = we_q;
    wbm_slave_addr_o  = AD_WIDTH'(addr_q[SLV_ADDR_LSB-1:0]);
    wbm_slave_wdata_o = wdata_q;
    wbm_slave_sel_o   = sel_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      resp_err_q <= 1'b0;
      rdata_q    <= '0;
    end else if ((state_q == IDLE) && req) begin
      addr_q     <= wbs_addr_i;
      wdata_q    <= wbs_wdata_i;
      sel_q      <= wbs_sel_i;
      we_q       <= wbs_we_i;
      idx_q      <= idx_full[IdxW-1:0];
      resp_err_q <= !mapped;
      rdata_q    <= mapped ? '0 : ErrData;
    end else if (state_q == ACCESS) begin
      if (sel_ack) begin
        rdata_q    <= sel_rdata;
        resp_err_q <= 1'b0;
      end else if (timeout) begin
        rdata_q    <= ErrData;
        resp_err_q <= 1'b1;
      end
    end
  end

  // A new error beats a simultaneous clear; otherwise the first error sticks.
  assign unmapped_ev = (state_q == IDLE) && req && !mapped;
  assign err_ev      = unmapped_ev || timeout;

  always_comb begin
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    if (err_ev && ((err_code_q == ERR_NONE) || err_clr_i)) begin
      err_code_d = unmapped_ev ? ERR_UNMAPPED : ERR_TIMEOUT;
      err_addr_d = unmapped_ev ? wbs_addr_i : addr_q;
    end else if (err_clr_i) begin
      err_code_d = ERR_NONE;
      err_addr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_code_q <= ERR_NONE;
      err_addr_q <= '0;
    end else begin
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_irq_o  = (err_code_q != ERR_NONE);
  assign err_addr_o = err_addr_q;
  assign err_code_o = err_code_q;

endmodule

// File: tb/tb_wb_perips_decoder.sv
// Scoreboard bench for wb_perips_decoder with a delay-programmable slave responder.
module tb_wb_perips_decoder;

  localparam int unsigned NS = 13;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              cyc, stb, we, err_clr;
  logic [31:0]       addr, wdata;
  logic [3:0]        sel;
  logic [31:0]       rdata_o, s_addr, s_wdata, e_addr;
  logic              ack_o, err_o, s_we, irq;
  logic [3:0]        s_sel;
  logic [1:0]        e_code;
  logic [NS-1:0]     s_cyc, s_stb, s_ack, extra_ack;
  logic [NS-1:0]     model_ack = '0;
  logic [NS*32-1:0]  s_rdata;

  assign s_ack = model_ack | extra_ack;
  for (genvar g = 0; g < NS; g++) begin : g_rdata
    assign s_rdata[g*32 +: 32] = 32'hA5A5_0000 | g;
  end

  wb_perips_decoder #(
    .NUM_SLAVES     (NS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .wbs_cyc_i         (cyc),
    .wbs_stb_i         (stb),
    .wbs_we_i          (we),
    .wbs_addr_i        (addr),
    .wbs_wdata_i       (wdata),
    .wbs_sel_i         (sel),
    .wbs_rdata_o       (rdata_o),
    .wbs_ack_o         (ack_o),
    .wbs_err_o         (err_o),
    .wbm_slave_cyc_o   (s_cyc),
    .wbm_slave_stb_o   (s_stb),
    .wbm_slave_we_o    (s_we),
    .wbm_slave_addr_o  (s_addr),
    .wbm_slave_wdata_o (s_wdata),
    .wbm_slave_sel_o   (s_sel),
    .slave_wbm_rdata_i (s_rdata),
    .slave_wbm_ack_i   (s_ack),
    .err_clr_i         (err_clr),
    .err_irq_o         (irq),
    .err_addr_o        (e_addr),
    .err_code_o        (e_code)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          t_drive;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   ack_delay[NS];  // ACCESS cycle in which a slave acks; 0 means silent
  int   cyc_cnt = 0;
  int   scnt = 0;
  bit   stb_seen = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Slave responder plus scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    model_ack = '0;
    if (s_stb != '0) begin
      stb_seen = 1'b1;
      scnt++;
      for (int i = 0; i < NS; i++) begin
        if (s_stb[i] && ack_delay[i] != 0 && scnt == ack_delay[i]) model_ack[i] = 1'b1;
      end
    end else begin
      scnt = 0;
    end
    check_val("err_without_ack", err_o & ~ack_o, 0);
    if (ack_o) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_ack", ack_o, 0);
      end else begin
        e = sb_q.pop_front();
        check_val("rdata", rdata_o, e.rdata);
        check_val("err", err_o, e.err);
        check_val("latency", cyc_cnt - e.t_drive, e.lat);
      end
    end
  end

  task automatic xfer(input logic w, input logic [31:0] a, input logic clr,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                      input logic [NS-1:0] exp_stb);
    bit got = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = $urandom; sel = 4'($urandom);
    err_clr = clr; stb_seen = 1'b0;
    sb_q.push_back('{exp_rd, exp_err, cyc_cnt, exp_lat});
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      err_clr = 1'b0;
      if (n == 0) begin
        check_val("stb_select", s_stb, exp_stb);
        check_val("cyc_select", s_cyc, exp_stb);
        if (exp_stb != '0) begin
          check_val("bcast_addr", s_addr, {20'h0, a[11:0]});
          check_val("bcast_wdata", s_wdata, wdata);
          check_val("bcast_sel", s_sel, sel);
          check_val("bcast_we", s_we, w);
        end
      end
      if (ack_o) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0;
    if (!got) begin
      check_val("ack_missing", ack_o, 1);
      sb_q.delete();
    end
    if (exp_stb == '0) check_val("no_strobe", stb_seen, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_ack_err"}, {ack_o, err_o}, 0);
    check_val({tag, "_rdata"}, rdata_o, 0);
    check_val({tag, "_stb_cyc"}, {s_stb, s_cyc}, 0);
    check_val({tag, "_bcast_addr"}, {s_we, s_sel, s_addr}, 0);
    check_val({tag, "_bcast_wdata"}, s_wdata, 0);
    check_val({tag, "_err_rec"}, {irq, e_code, e_addr}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int acks;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
    err_clr = 1'b0; extra_ack = '0;
    for (int i = 0; i < NS; i++) ack_delay[i] = 1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Mapped read; a stray ack from slave 7 must be ignored.
    ack_delay[2] = 2;
    extra_ack = NS'(1) << 7;
    xfer(1'b0, 32'h1000_2004, 1'b0, 32'hA5A5_0002, 1'b0, 3, NS'(1) << 2);
    extra_ack = '0;
    check_val("irq_after_ok", irq, 0);

    // Unmapped write past the last window.
    xfer(1'b1, 32'h1000_D000, 1'b0, 32'hDEAD_BEEF, 1'b1, 1, '0);
    check_val("unmapped_code", e_code, 1);
    check_val("unmapped_addr", e_addr, 32'h1000_D000);
    check_val("unmapped_irq", irq, 1);

    // Below base: record must stay with the first error.
    xfer(1'b0, 32'h0000_0100, 1'b0, 32'hDEAD_BEEF, 1'b1, 1, '0);
    check_val("sticky_addr", e_addr, 32'h1000_D000);

    // Clear coincident with a new error records the new one.
    xfer(1'b0, 32'h1001_0000, 1'b1, 32'hDEAD_BEEF, 1'b1, 1, '0);
    check_val("clr_new_code", e_code, 1);
    check_val("clr_new_addr", e_addr, 32'h1001_0000);

    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    check_val("cleared_irq", irq, 0);
    check_val("cleared_code", e_code, 0);

    // Ack in the last allowed ACCESS cycle.
    ack_delay[5] = TO;
    xfer(1'b0, 32'h1000_5008, 1'b0, 32'hA5A5_0005, 1'b0, TO + 1, NS'(1) << 5);
    check_val("late_ok_irq", irq, 0);

    ack_delay[5] = 0;
`ifdef WB_DEC_TIMEOUT_EN
    xfer(1'b0, 32'h1000_5008, 1'b0, 32'hDEAD_BEEF, 1'b1, TO + 1, NS'(1) << 5);
    check_val("timeout_code", e_code, 2);
    check_val("timeout_addr", e_addr, 32'h1000_5008);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
`else
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h1000_5008;
    acks = 0;
    repeat (1000) begin
      @(negedge clk);
      if (ack_o) acks++;
    end
    check_val("untimed_no_ack", acks, 0);
    check_val("untimed_still_stb", s_stb, NS'(1) << 5);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check_val("untimed_abort_stb", s_stb, 0);
    check_val("untimed_code", e_code, 0);
`endif

    // Abort during ACCESS on slave 3, then a late ack.
    ack_delay[3] = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h1000_3010;
    repeat (3) @(negedge clk);
    check_val("abort_stb_before", s_stb, NS'(1) << 3);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check_val("abort_stb_after", s_stb, 0);
    extra_ack = NS'(1) << 3;
    @(negedge clk) extra_ack = '0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack_o) acks++;
    end
    check_val("abort_late_ack", acks, 0);

    // Leave an error recorded, then reset mid-ACCESS.
    xfer(1'b0, 32'h2000_0000, 1'b0, 32'hDEAD_BEEF, 1'b1, 1, '0);
    check_val("pre_reset_irq", irq, 1);
    ack_delay[4] = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h1000_4000; wdata = 32'h1234_5678; sel = 4'hF;
    repeat (3) @(negedge clk);
    check_val("pre_reset_stb", s_stb, NS'(1) << 4);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    ack_delay[4] = 1;
    xfer(1'b0, 32'h1000_4000, 1'b0, 32'hA5A5_0004, 1'b0, 2, NS'(1) << 4);

    repeat (3) @(negedge clk);
    check_val("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
